o_buf_controller: RTL and testbench
===================================

Name: o_buf_controller

Overview:
- Readout side of the linebuffer: generates 8-bit video timing (hsync, vsync, vde) and streams pixels out of the 32-bit linebuffer BRAM.
- Unpacks 4 pixels per word, MSB byte first (byte [31:24] = first/leftmost pixel); byte addresses step by 4 and restart at 0 every line.
- Pulses line/frame request interrupts so the processing system can DMA the next line from the DRAM framebuffer.

Parameters:
- ADDRESS_WIDTH, 32, linebuffer address width.
- H_ACTIVE, 640, active pixels per line; must be a multiple of 4.
- H_FRONT, 16, horizontal front porch (pclk).
- H_SYNC, 96, hsync pulse width (pclk).
- H_BACK, 48, horizontal back porch (pclk).
- V_ACTIVE, 480, active lines per frame.
- V_FRONT, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BACK, 33, vertical back porch (lines).

Ports:
- pclk  input  1  pixel clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  run request; sampled only at frame start
- rd_data  input  32  linebuffer read data; 1-cycle BRAM latency
- re  output  1  linebuffer read enable
- addr  output  ADDRESS_WIDTH  linebuffer byte address
- o_data  output  8  output pixel
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- vde  output  1  video data enable
- line_req  output  1  one-pclk pulse: linebuffer free for next line
- frame_req  output  1  one-pclk pulse: frame finished

Behaviour:
- Reset values: re=0, addr=0, o_data=0, hsync=1, vsync=1, vde=0, line_req=0, frame_req=0. Counters h=0, v=0, state IDLE.
- Counters:
  - h runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK.
  - v increments when h wraps, 0..V_TOTAL-1.
  - Both are 13-bit.
  - Order within a line/frame: active, front porch, sync, back porch.
- States:
  - IDLE: counters held at 0.
  - IDLE→RUN when enable=1 is sampled in IDLE.
  - In RUN, enable is re-sampled only at (h=H_TOTAL-1, v=V_TOTAL-1): if 0, go to IDLE after the frame completes; if 1, wrap to h=0, v=0 and continue.
  - Deasserting enable mid-frame never truncates a frame.
- Fetch (stage 0 = counter cycle):
  - When h<H_ACTIVE, v<V_ACTIVE and h[1:0]=0: next cycle re=1, addr=h (word k at byte address 4k).
  - Otherwise re=0; addr holds its value.
  - The line starts at addr=0 again.
- Unpack:
  - rd_data is valid 2 cycles after stage 0.
  - On that edge: o_data<=rd_data[31:24] and a shift register<=rd_data.
  - The following 3 cycles output bytes [23:16], [15:8], [7:0].
- Alignment:
  - hsync, vsync and vde are decoded at stage 0 and delayed by 3 registers.
  - Pipeline latency from counter to pins is 3 pclk; all outputs are mutually aligned.
  - o_data=0 whenever the delayed vde=0.
- Sync decode:
  - hsync=0 for H_ACTIVE+H_FRONT ≤ h < H_ACTIVE+H_FRONT+H_SYNC.
  - vsync=0 for V_ACTIVE+V_FRONT ≤ v < V_ACTIVE+V_FRONT+V_SYNC, across whole lines.
  - vde = (h<H_ACTIVE && v<V_ACTIVE).
- line_req: 1-cycle pulse, same cycle as the falling edge of output vde on every active line. The last word has been consumed, so software may overwrite the buffer.
- frame_req: 1-cycle pulse aligned with the output of (h=0, v=V_ACTIVE), i.e. start of vertical blanking.
- In IDLE: syncs are held inactive (1), vde=0, and no interrupts fire. Pipeline stages drain normally.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous); restart requires enable.
- addr upper bits above the range needed for H_ACTIVE are always 0.

Test Plan:
Use small parameters for simulation: H_ACTIVE=8, H_FRONT=2, H_SYNC=2, H_BACK=4 (H_TOTAL=16); V_ACTIVE=3, V_FRONT=1, V_SYNC=1, V_BACK=1 (V_TOTAL=6).
1. Reset, then hold enable=0 for 100 cycles → re=0, hsync=vsync=1, vde=0, o_data=0, no req pulses.
2. enable=1, BRAM model returns 0x00010203 at addr 0 and 0x04050607 at addr 4 → each active line has re pulses at addr 0 then 4, four cycles apart; o_data=00,01,...,07 on 8 consecutive vde-high cycles; first vde 3 cycles after the RUN counter reaches h=0.
3. Full-frame timing → per line: 8 vde-high cycles, hsync low exactly 2 cycles, starting 2 cycles after vde falls; vsync low for exactly 16 cycles (1 line) per 96-cycle frame.
4. Interrupts over one frame → exactly 3 line_req pulses, each coincident with a vde falling edge; exactly 1 frame_req, 48 cycles after the first vde rise of the frame (start of line 3).
5. Drop enable at h=5, v=1 → current frame completes (all 3 lines, vsync pulse), then IDLE with outputs idle; re-raise enable → new frame starts with addr=0.
6. Assert reset at h=6, v=2 → all outputs return to reset values in the same cycle, no residual pixels; after release plus enable, the frame restarts cleanly at addr 0.

Source files
------------

// File: rtl/o_buf_controller.sv
// Linebuffer readout: video timing generator plus 32-bit to 8-bit pixel unpacker.
// A three-stage pipeline keeps pixels, syncs and interrupts mutually aligned.
module o_buf_controller #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int H_ACTIVE      = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33
) (
    input  logic                     pclk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [31:0]              rd_data,
    output logic                     re,
    output logic [ADDRESS_WIDTH-1:0] addr,
    output logic [7:0]               o_data,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     vde,
    output logic                     line_req,
    output logic                     frame_req
);

    localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
    localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
    localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FRONT);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FRONT);
    localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [12:0] H_LAST   = 13'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [12:0] V_LAST   = 13'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q;
    logic [12:0] h_q;
    logic [12:0] v_q;

    // enable only matters in IDLE or on the very last pixel of a frame
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    h_q <= '0;
                    v_q <= '0;
                    if (enable) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (h_q == H_LAST) begin
                        h_q <= '0;
                        if (v_q == V_LAST) begin
                            v_q <= '0;
                            if (!enable) begin
                                state_q <= IDLE;
                            end
                        end else begin
                            v_q <= v_q + 13'd1;
                        end
                    end else begin
                        h_q <= h_q + 13'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic run_s0;
    logic de_s0;
    logic fetch_s0;
    logic hs_s0;
    logic vs_s0;
    logic fr_s0;

    always_comb begin
        run_s0   = (state_q == RUN);
        de_s0    = run_s0 && (h_q < H_ACT) && (v_q < V_ACT);
        fetch_s0 = de_s0 && (h_q[1:0] == 2'b00);
        hs_s0    = !(run_s0 && (h_q >= HS_START) && (h_q < HS_END));
        vs_s0    = !(run_s0 && (v_q >= VS_START) && (v_q < VS_END));
        fr_s0    = run_s0 && (h_q == 13'd0) && (v_q == V_ACT);
    end

    logic        de_s1_q, de_s2_q;
    logic        hs_s1_q, hs_s2_q;
    logic        vs_s1_q, vs_s2_q;
    logic        fr_s1_q, fr_s2_q;
    logic        load_q;
    logic [31:0] shift_q;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            re        <= 1'b0;
            addr      <= '0;
            load_q    <= 1'b0;
            shift_q   <= '0;
            o_data    <= '0;
            de_s1_q   <= 1'b0;
            de_s2_q   <= 1'b0;
            vde       <= 1'b0;
            hs_s1_q   <= 1'b1;
            hs_s2_q   <= 1'b1;
            hsync     <= 1'b1;
            vs_s1_q   <= 1'b1;
            vs_s2_q   <= 1'b1;
            vsync     <= 1'b1;
            fr_s1_q   <= 1'b0;
            fr_s2_q   <= 1'b0;
            frame_req <= 1'b0;
            line_req  <= 1'b0;
        end else begin
            re <= fetch_s0;
            if (fetch_s0) begin
                addr <= ADDRESS_WIDTH'(h_q);
            end
            // BRAM data for the word requested by re arrives one cycle later
            load_q <= re;
            if (load_q) begin
                o_data  <= rd_data[31:24];
                shift_q <= {rd_data[23:0], 8'h00};
            end else if (de_s2_q) begin
                o_data  <= shift_q[31:24];
                shift_q <= {shift_q[23:0], 8'h00};
            end else begin
                o_data  <= 8'h00;
            end

            de_s1_q   <= de_s0;
            de_s2_q   <= de_s1_q;
            vde       <= de_s2_q;
            hs_s1_q   <= hs_s0;
            hs_s2_q   <= hs_s1_q;
            hsync     <= hs_s2_q;
            vs_s1_q   <= vs_s0;
            vs_s2_q   <= vs_s1_q;
            vsync     <= vs_s2_q;
            fr_s1_q   <= fr_s0;
            fr_s2_q   <= fr_s1_q;
            frame_req <= fr_s2_q;
            // fires together with the falling edge of the vde pin
            line_req  <= vde && !de_s2_q;
        end
    end

endmodule

// File: tb/tb_o_buf_controller.sv
// Randomized bench for o_buf_controller; a raster-position history model predicts every pin each cycle.
module tb_o_buf_controller;

    localparam int HA = 8, HF = 2, HS = 2, HB = 4;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] rd_data = 32'h0;
    logic        re;
    logic [31:0] addr;
    logic [7:0]  o_data;
    logic        hsync, vsync, vde, line_req, frame_req;

    o_buf_controller #(
        .ADDRESS_WIDTH(32),
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .pclk(pclk), .reset(reset), .enable(enable), .rd_data(rd_data),
        .re(re), .addr(addr), .o_data(o_data), .hsync(hsync), .vsync(vsync),
        .vde(vde), .line_req(line_req), .frame_req(frame_req)
    );

    always #5 pclk = ~pclk;

    // linebuffer: two 32-bit words, one cycle read latency
    logic [31:0] mem [0:1];
    always @(posedge pclk) begin
        if (re) rd_data <= mem[addr[2]];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model: raster position of every recent cycle, newest first
    typedef struct {
        bit         run;
        int         h;
        int         v;
        logic [7:0] pix;
    } pos_t;

    pos_t        hist [5];
    bit          m_run;
    int          m_h, m_v;
    logic [31:0] exp_addr;
    bit          rand_mem;
    bit          count_frames;
    bit          seen_fr;
    int          cnt_de, cnt_lr, cnt_hs, cnt_vs, n_frames;

    function automatic bit is_de(input pos_t p);
        return p.run && (p.h < HA) && (p.v < VA);
    endfunction

    function automatic logic [7:0] pixel_at(input int h);
        logic [31:0] w;
        if (h >= HA) return 8'h00;
        w = mem[h / 4];
        return w[31 - 8 * (h % 4) -: 8];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) hist[i] = '{run: 1'b0, h: 0, v: 0, pix: 8'h00};
        m_run    = 1'b0;
        m_h      = 0;
        m_v      = 0;
        exp_addr = 32'h0;
    endtask

    task automatic step();
        pos_t        p1, p3, p4;
        bit          e_re, e_de, e_hs, e_vs, e_fr, e_lr;
        logic [7:0]  e_od;
        @(posedge pclk);
        if (reset) begin
            model_reset();
        end else begin
            if (!m_run) begin
                m_run = enable;
                m_h = 0;
                m_v = 0;
            end else if (m_h == HT - 1 && m_v == VT - 1) begin
                m_h = 0;
                m_v = 0;
                m_run = enable;
            end else if (m_h == HT - 1) begin
                m_h = 0;
                m_v++;
            end else begin
                m_h++;
            end
            for (int i = 4; i > 0; i--) hist[i] = hist[i - 1];
            hist[0] = '{run: m_run, h: m_h, v: m_v, pix: pixel_at(m_h)};
        end
        p1 = hist[1];
        p3 = hist[3];
        p4 = hist[4];
        e_re = is_de(p1) && (p1.h % 4 == 0);
        if (e_re) exp_addr = 32'(p1.h);
        e_de = is_de(p3);
        e_hs = !(p3.run && p3.h >= HA + HF && p3.h < HA + HF + HS);
        e_vs = !(p3.run && p3.v >= VA + VF && p3.v < VA + VF + VS);
        e_od = e_de ? p3.pix : 8'h00;
        e_fr = p3.run && p3.h == 0 && p3.v == VA;
        e_lr = is_de(p4) && !e_de;
        #1;
        check_eq("re", re, e_re);
        check_eq("addr", addr, exp_addr);
        check_eq("o_data", o_data, e_od);
        check_eq("hsync", hsync, e_hs);
        check_eq("vsync", vsync, e_vs);
        check_eq("vde", vde, e_de);
        check_eq("line_req", line_req, e_lr);
        check_eq("frame_req", frame_req, e_fr);

        if (frame_req) begin
            if (count_frames && seen_fr) begin
                n_frames++;
                $display("frame %0d: vde=%0d line_req=%0d hsync_low=%0d vsync_low=%0d",
                         n_frames, cnt_de, cnt_lr, cnt_hs, cnt_vs);
                check_eq("frame_vde_cycles", cnt_de, VA * HA);
                check_eq("frame_line_reqs", cnt_lr, VA);
                check_eq("frame_hsync_low", cnt_hs, VT * HS);
                check_eq("frame_vsync_low", cnt_vs, VS * HT);
            end
            seen_fr = 1'b1;
            cnt_de = 0; cnt_lr = 0; cnt_hs = 0; cnt_vs = 0;
        end
        cnt_de += int'(vde);
        cnt_lr += int'(line_req);
        cnt_hs += int'(!hsync);
        cnt_vs += int'(!vsync);

        // software refills the buffer once the previous line is consumed
        if (e_lr && rand_mem) begin
            mem[0] = $urandom;
            mem[1] = $urandom;
        end
    endtask

    task automatic wait_pos(input int h, input int v);
        int n;
        n = 0;
        while (!(m_run && m_h == h && m_v == v) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_pos: position (%0d,%0d) not reached, got (%0d,%0d)", h, v, m_h, m_v);
        end
    endtask

    task automatic do_reset(input int hold);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_eq("rst_re", re, 1'b0);
        check_eq("rst_addr", addr, 32'h0);
        check_eq("rst_o_data", o_data, 8'h00);
        check_eq("rst_hsync", hsync, 1'b1);
        check_eq("rst_vsync", vsync, 1'b1);
        check_eq("rst_vde", vde, 1'b0);
        check_eq("rst_line_req", line_req, 1'b0);
        check_eq("rst_frame_req", frame_req, 1'b0);
        repeat (hold) step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        model_reset();
        rand_mem = 1'b0;
        count_frames = 1'b0;
        seen_fr = 1'b0;
        cnt_de = 0; cnt_lr = 0; cnt_hs = 0; cnt_vs = 0; n_frames = 0;
        mem[0] = 32'h00010203;
        mem[1] = 32'h04050607;

        // held in reset, then idle with enable low
        repeat (3) step();
        reset = 1'b0;
        repeat (100) step();

        // continuous frames with the fixed buffer contents
        enable = 1'b1;
        count_frames = 1'b1;
        repeat (3 * HT * VT + 10) step();
        count_frames = 1'b0;
        rand_mem = 1'b1;

        // drop enable mid-frame: frame must complete before IDLE
        wait_pos(5, 1);
        enable = 1'b0;
        n = 0;
        while (m_run && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: model still running after %0d cycles", n);
        end
        repeat (30) step();
        enable = 1'b1;
        repeat (HT * VT + 20) step();

        // reset in the middle of an active line
        wait_pos(6, 2);
        do_reset(2);
        repeat (HT * VT + 20) step();

        // random enable toggling, buffer contents and occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(39, 0) == 0) enable = ~enable;
            if ($urandom_range(999, 0) == 0) do_reset($urandom_range(3, 1));
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
